// File: rtl/aes_pkg.sv
// Shared AES round-datapath constants and the Rijndael ShiftRows row-offset rule.
// Pure definitions; no logic, no latency, no flow control.
package aes_pkg;

    localparam int NB_MIN = 4;
    localparam int NB_MAX = 8;

    localparam logic MODE_ENC = 1'b1;
    localparam logic MODE_DEC = 1'b0;

    // Rijndael widens the offsets of rows 2 and 3 for the largest block sizes.
    function automatic int shift_offset(input int nb, input int row);
        case (row)
            0:       return 0;
            1:       return 1;
            2:       return (nb == 8) ? 3 : 2;
            default: return (nb >= 7) ? 4 : 3;
        endcase
    endfunction

endpackage

// File: rtl/shift_rows_nb.sv
// Combinational forward/inverse ShiftRows over an NB-column state; zero latency.
// No handshake: the byte permutation is selected by enc_dec and fixed at elaboration.
module shift_rows_nb
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] data_in,
    input  logic             enc_dec,
    output logic [32*NB-1:0] data_out
);

    if (NB < NB_MIN || NB > NB_MAX) begin : g_bad_nb
        $error("shift_rows_nb: NB=%0d outside %0d..%0d", NB, NB_MIN, NB_MAX);
    end

    logic [32*NB-1:0] w_fwd;
    logic [32*NB-1:0] w_inv;

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int CR    = shift_offset(NB, r);
            localparam int SRC_F = r + 4 * ((c + CR) % NB);
            localparam int SRC_I = r + 4 * ((c - CR + NB) % NB);
            assign w_fwd[8*(4*c+r) +: 8] = data_in[8*SRC_F +: 8];
            assign w_inv[8*(4*c+r) +: 8] = data_in[8*SRC_I +: 8];
        end
    end

    assign data_out = (enc_dec == MODE_ENC) ? w_fwd : w_inv;

endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows with per-transfer direction and tag; latency PIPE_DEPTH cycles, 1 transfer/cycle.
// Valid/ready per stage: empty stages fill under a stalled sink; in_ready drops only when all stages are full and out_ready is low.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB         = 4,
    parameter int PIPE_DEPTH = 1,
    parameter int TAG_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_enc_dec,
    input  logic [32*NB-1:0]                in_data,
    input  logic [TAG_W-1:0]                in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [32*NB-1:0]                out_data,
    output logic                            out_enc_dec,
    output logic [TAG_W-1:0]                out_tag,
    output logic [$clog2(PIPE_DEPTH+1)-1:0] occupancy,
    output logic                            busy
);

    localparam int W  = 32 * NB;
    localparam int OW = $clog2(PIPE_DEPTH + 1);

    if (NB < NB_MIN || NB > NB_MAX) begin : g_bad_nb
        $error("shift_rows_pipe: NB=%0d outside %0d..%0d", NB, NB_MIN, NB_MAX);
    end
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
        $error("shift_rows_pipe: PIPE_DEPTH=%0d outside 1..4", PIPE_DEPTH);
    end

    logic [W-1:0] w_perm;

    shift_rows_nb #(
        .NB(NB)
    ) u_perm (
        .data_in (in_data),
        .enc_dec (in_enc_dec),
        .data_out(w_perm)
    );

    logic [PIPE_DEPTH-1:0] r_vld;
    logic [PIPE_DEPTH-1:0] r_mode;
    logic [W-1:0]          r_dat [PIPE_DEPTH];
    logic [TAG_W-1:0]      r_tag [PIPE_DEPTH];

    logic [PIPE_DEPTH-1:0] w_rdy;
    logic [PIPE_DEPTH-1:0] w_dn_rdy;
    logic [PIPE_DEPTH-1:0] w_load;
    logic [PIPE_DEPTH-1:0] w_vld_nxt;
    logic [PIPE_DEPTH-1:0] w_src_mode;
    logic [W-1:0]          w_src_dat [PIPE_DEPTH];
    logic [TAG_W-1:0]      w_src_tag [PIPE_DEPTH];

    for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_stage
        // Unrolled ready chain: a stage is blocked only if it and every later stage hold data against a stalled sink.
        assign w_rdy[s] = out_ready | ~(&r_vld[PIPE_DEPTH-1:s]);

        if (s == PIPE_DEPTH - 1) begin : g_tail
            assign w_dn_rdy[s] = out_ready;
        end else begin : g_mid
            assign w_dn_rdy[s] = w_rdy[s+1];
        end

        if (s == 0) begin : g_head
            assign w_load[s]     = in_valid & w_rdy[s];
            assign w_src_dat[s]  = w_perm;
            assign w_src_tag[s]  = in_tag;
            assign w_src_mode[s] = in_enc_dec;
        end else begin : g_body
            assign w_load[s]     = r_vld[s-1] & w_rdy[s];
            assign w_src_dat[s]  = r_dat[s-1];
            assign w_src_tag[s]  = r_tag[s-1];
            assign w_src_mode[s] = r_mode[s-1];
        end

        assign w_vld_nxt[s] = w_load[s] | (r_vld[s] & ~w_dn_rdy[s]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_mode <= '0;
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                r_dat[s] <= '0;
                r_tag[s] <= '0;
            end
        end else begin
            r_vld <= w_vld_nxt;
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                if (w_load[s]) begin
                    r_dat[s]  <= w_src_dat[s];
                    r_tag[s]  <= w_src_tag[s];
                    r_mode[s] <= w_src_mode[s];
                end
            end
        end
    end

    logic          w_in_acc;
    logic          w_out_acc;
    logic [OW-1:0] r_occ;

    assign w_in_acc  = in_valid & in_ready;
    assign w_out_acc = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
        end else if (w_in_acc && !w_out_acc) begin
            r_occ <= r_occ + OW'(1);
        end else if (!w_in_acc && w_out_acc) begin
            r_occ <= r_occ - OW'(1);
        end
    end

    assign in_ready    = w_rdy[0];
    assign out_valid   = r_vld[PIPE_DEPTH-1];
    assign out_data    = r_dat[PIPE_DEPTH-1];
    assign out_tag     = r_tag[PIPE_DEPTH-1];
    assign out_enc_dec = r_mode[PIPE_DEPTH-1];
    assign occupancy   = r_occ;
    assign busy        = (r_occ != '0);

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: four instances (NB4/D1, NB4/D3 enc->dec chain, NB8/D2) against a byte-matrix reference and scoreboards.
module tb_shift_rows_pipe;
    import aes_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: NB=4, PIPE_DEPTH=1
    logic         ra, a_iv, a_ir, a_ie, a_ov, a_or, a_oe, a_busy;
    logic [127:0] a_id, a_od;
    logic [3:0]   a_it, a_ot;
    logic [0:0]   a_occ;
    // Instances E (encrypt) -> D (decrypt): NB=4, PIPE_DEPTH=3
    logic         re, e_iv, e_ir, e_ie, e_ov, e_or, e_oe, e_busy;
    logic [127:0] e_id, e_od;
    logic [3:0]   e_it, e_ot;
    logic [1:0]   e_occ;
    logic         d_ov, d_or, d_oe, d_busy;
    logic [127:0] d_od;
    logic [3:0]   d_ot;
    logic [1:0]   d_occ;
    // Instance B: NB=8, PIPE_DEPTH=2
    logic         rb, b_iv, b_ir, b_ie, b_ov, b_or, b_oe, b_busy;
    logic [255:0] b_id, b_od;
    logic [3:0]   b_it, b_ot;
    logic [1:0]   b_occ;

    shift_rows_pipe #(.NB(4), .PIPE_DEPTH(1), .TAG_W(4)) u_a (
        .clk(clk), .rst(ra), .in_valid(a_iv), .in_ready(a_ir), .in_enc_dec(a_ie), .in_data(a_id),
        .in_tag(a_it), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_enc_dec(a_oe),
        .out_tag(a_ot), .occupancy(a_occ), .busy(a_busy));

    shift_rows_pipe #(.NB(4), .PIPE_DEPTH(3), .TAG_W(4)) u_e (
        .clk(clk), .rst(re), .in_valid(e_iv), .in_ready(e_ir), .in_enc_dec(e_ie), .in_data(e_id),
        .in_tag(e_it), .out_valid(e_ov), .out_ready(e_or), .out_data(e_od), .out_enc_dec(e_oe),
        .out_tag(e_ot), .occupancy(e_occ), .busy(e_busy));

    shift_rows_pipe #(.NB(4), .PIPE_DEPTH(3), .TAG_W(4)) u_d (
        .clk(clk), .rst(re), .in_valid(e_ov), .in_ready(e_or), .in_enc_dec(MODE_DEC), .in_data(e_od),
        .in_tag(e_ot), .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .out_enc_dec(d_oe),
        .out_tag(d_ot), .occupancy(d_occ), .busy(d_busy));

    shift_rows_pipe #(.NB(8), .PIPE_DEPTH(2), .TAG_W(4)) u_b (
        .clk(clk), .rst(rb), .in_valid(b_iv), .in_ready(b_ir), .in_enc_dec(b_ie), .in_data(b_id),
        .in_tag(b_it), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_enc_dec(b_oe),
        .out_tag(b_ot), .occupancy(b_occ), .busy(b_busy));

    // Reference: unpack to a 4 x nb byte matrix, rotate each row by its Rijndael offset, repack.
    function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input logic enc);
        logic [7:0]   st [4][8];
        logic [255:0] o;
        int           off [4];
        int           src;
        off[0] = 0;
        off[1] = 1;
        off[2] = (nb == 8) ? 3 : 2;
        off[3] = (nb >= 7) ? 4 : 3;
        o = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) st[r][c] = d[8*(4*c+r) +: 8];
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                src = enc ? (c + off[r]) % nb : (c - off[r] + nb) % nb;
                o[8*(4*c+r) +: 8] = st[r][src];
            end
        return o;
    endfunction

    function automatic logic [255:0] rnd();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [255:0] dat;
        logic [3:0]   tag;
        logic         mode;
        int           cyc;
    } exp_t;

    exp_t q0[$], q1[$], q2[$], q3[$];
    bit           lat_on [4];
    bit           hold_v [4];
    logic [255:0] hold_d [4];
    logic [3:0]   hold_t [4];
    logic         hold_m [4];

    function automatic int qsize(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic qpush(input int id, input exp_t e);
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic qpop(input int id, output exp_t e);
        case (id)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    task automatic qflush(input int id);
        case (id)
            0: q0.delete();
            1: q1.delete();
            2: q2.delete();
            default: q3.delete();
        endcase
    endtask

    function automatic int lat_of(input int id);
        case (id)
            0: return 1;
            1: return 3;
            2: return 6;
            default: return 2;
        endcase
    endfunction

    function automatic int dep_of(input int id);
        case (id)
            0: return 1;
            3: return 2;
            default: return 3;
        endcase
    endfunction

    // Runs each negedge: the handshakes seen here are the ones the next posedge will commit.
    task automatic mon(input int id, input logic rst_i, input logic iv, input logic ir, input logic ie,
                       input logic [255:0] idat, input logic [3:0] itag, input logic ov, input logic orr,
                       input logic oe, input logic [255:0] odat, input logic [3:0] otag, input int occ,
                       input int nb);
        exp_t e;
        if (id != 2) begin
            chk($sformatf("occupancy%0d", id), 256'(occ), 256'(qsize(id)));
            chk($sformatf("in_ready%0d", id), 256'(ir), 256'(!(qsize(id) == dep_of(id) && !orr)));
        end
        if (hold_v[id]) begin
            chk($sformatf("hold_vld%0d", id), 256'(ov), 256'(1));
            chk($sformatf("hold_dat%0d", id), odat, hold_d[id]);
            chk($sformatf("hold_tag%0d", id), 256'(otag), 256'(hold_t[id]));
            chk($sformatf("hold_mode%0d", id), 256'(oe), 256'(hold_m[id]));
        end
        hold_v[id] = ov && !orr && !rst_i;
        hold_d[id] = odat;
        hold_t[id] = otag;
        hold_m[id] = oe;
        if (rst_i) begin
            qflush(id);
            return;
        end
        if (ov && orr) begin
            chk($sformatf("out_expected%0d", id), 256'(qsize(id) != 0), 256'(1));
            if (qsize(id) != 0) begin
                qpop(id, e);
                chk($sformatf("sb_dat%0d", id), odat, e.dat);
                chk($sformatf("sb_tag%0d", id), 256'(otag), 256'(e.tag));
                chk($sformatf("sb_mode%0d", id), 256'(oe), 256'(e.mode));
                if (lat_on[id]) chk($sformatf("latency%0d", id), 256'(cyc - e.cyc), 256'(lat_of(id)));
            end
        end
        if (iv && ir && id != 2) begin
            e.dat  = ref_shift(idat, nb, ie);
            e.tag  = itag;
            e.mode = ie;
            e.cyc  = cyc;
            qpush(id, e);
            if (id == 1) begin
                e.dat  = idat;
                e.mode = MODE_DEC;
                qpush(2, e);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ra, a_iv, a_ir, a_ie, 256'(a_id), a_it, a_ov, a_or, a_oe, 256'(a_od), a_ot, int'(a_occ), 4);
        mon(1, re, e_iv, e_ir, e_ie, 256'(e_id), e_it, e_ov, e_or, e_oe, 256'(e_od), e_ot, int'(e_occ), 4);
        mon(2, re, e_ov, e_or, 1'b0, 256'(e_od), e_ot, d_ov, d_or, d_oe, 256'(d_od), d_ot, int'(d_occ), 4);
        mon(3, rb, b_iv, b_ir, b_ie, b_id, b_it, b_ov, b_or, b_oe, b_od, b_ot, int'(b_occ), 8);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected end before 100000 time units");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         enc;
        logic [127:0] din;
        logic [3:0]   tag;
        logic [127:0] dout;
    } vec_t;

    vec_t         tbl [6];
    logic [255:0] orig, mid;
    logic [127:0] got_d [4];
    logic [3:0]   got_t [4];
    int           n_got, sent;
    bit           acc, saw_full;

    initial begin
        ra = 1; re = 1; rb = 1;
        a_iv = 0; a_ie = 0; a_id = '0; a_it = '0; a_or = 1;
        e_iv = 0; e_ie = 0; e_id = '0; e_it = '0; d_or = 1;
        b_iv = 0; b_ie = 0; b_id = '0; b_it = '0; b_or = 1;

        tbl[0] = '{1'b1, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 4'h1, 128'h0B06010C_07020D08_030E0904_0F0A0500};
        tbl[1] = '{1'b0, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 4'h2, 128'h0306090C_0F020508_0B0E0104_070A0D00};
        tbl[2] = '{1'b1, 128'h00000000_00000000_00000000_00000100, 4'h3, 128'h00000100_00000000_00000000_00000000};
        tbl[3] = '{1'b0, 128'h00000000_00000000_00000000_00000100, 4'h4, 128'h00000000_00000000_00000100_00000000};
        tbl[4] = '{1'b1, {16{8'hA5}},                             4'hF, {16{8'hA5}}};
        tbl[5] = '{1'b1, 128'h00000000_00000000_00000000_FF000000, 4'h6, 128'h00000000_00000000_FF000000_00000000};

        repeat (2) tick();
        ra = 0; re = 0; rb = 0;

        // Reset state
        chk("rst_a_vld", 256'(a_ov), 0);   chk("rst_a_occ", 256'(a_occ), 0); chk("rst_a_busy", 256'(a_busy), 0);
        chk("rst_a_dat", 256'(a_od), 0);   chk("rst_a_tag", 256'(a_ot), 0);  chk("rst_a_mode", 256'(a_oe), 0);
        chk("rst_a_rdy", 256'(a_ir), 1);   chk("rst_b_vld", 256'(b_ov), 0);  chk("rst_b_occ", 256'(b_occ), 0);
        chk("rst_b_dat", b_od, 0);         chk("rst_b_rdy", 256'(b_ir), 1);  chk("rst_e_busy", 256'(e_busy), 0);
        chk("rst_d_vld", 256'(d_ov), 0);

        // Table vectors, back to back through the single-stage instance
        lat_on[0] = 1;
        for (int i = 0; i < 6; i++) begin
            a_iv = 1; a_ie = tbl[i].enc; a_id = tbl[i].din; a_it = tbl[i].tag;
            tick();
            chk($sformatf("tbl%0d_vld", i), 256'(a_ov), 1);
            chk($sformatf("tbl%0d_dat", i), 256'(a_od), 256'(tbl[i].dout));
            chk($sformatf("tbl%0d_tag", i), 256'(a_ot), 256'(tbl[i].tag));
            chk($sformatf("tbl%0d_mode", i), 256'(a_oe), 256'(tbl[i].enc));
        end
        a_iv = 0;
        tick();
        chk("tbl_drain_vld", 256'(a_ov), 0);
        chk("tbl_drain_busy", 256'(a_busy), 0);

        // Simultaneous accept on a full single stage
        a_iv = 1; a_id = 128'(rnd()); a_ie = 1'($urandom_range(0, 1)); a_it = 4'($urandom);
        tick();
        for (int i = 0; i < 10; i++) begin
            a_id = 128'(rnd()); a_ie = 1'($urandom_range(0, 1)); a_it = 4'($urandom);
            tick();
            chk("simul_occ", 256'(a_occ), 1);
            chk("simul_vld", 256'(a_ov), 1);
        end
        a_iv = 0;
        tick();

        // NB=8 spot bytes, then enc->dec round trip
        lat_on[3] = 1;
        for (int k = 0; k < 32; k++) orig[8*k +: 8] = 8'(k);
        b_iv = 1; b_ie = MODE_ENC; b_id = orig; b_it = 4'h3;
        tick();
        b_iv = 0;
        tick();
        chk("nb8_vld", 256'(b_ov), 1);
        chk("nb8_byte3", 256'(b_od[31:24]), 256'(8'h13));
        chk("nb8_byte2", 256'(b_od[23:16]), 256'(8'h0E));
        chk("nb8_byte1", 256'(b_od[15:8]), 256'(8'h05));
        chk("nb8_byte0", 256'(b_od[7:0]), 256'(8'h00));
        mid = b_od;
        b_iv = 1; b_ie = MODE_DEC; b_id = mid; b_it = 4'h4;
        tick();
        b_iv = 0;
        tick();
        chk("nb8_rt_vld", 256'(b_ov), 1);
        chk("nb8_rt_dat", b_od, orig);
        tick();

        // Backpressure: 5 transfers, sink stalled on cycles 2..6
        lat_on[3] = 0;
        sent = 0; saw_full = 0;
        b_iv = 1; b_id = rnd(); b_ie = 1'($urandom_range(0, 1)); b_it = 4'(sent);
        for (int t = 0; t < 20; t++) begin
            b_or = !(t >= 2 && t <= 6);
            #1;
            acc = b_iv && b_ir;
            if (b_occ == 2'd2 && !b_ir) saw_full = 1;
            tick();
            if (acc) begin
                sent++;
                if (sent < 5) begin
                    b_id = rnd(); b_ie = 1'($urandom_range(0, 1)); b_it = 4'(sent);
                end else b_iv = 0;
            end
        end
        chk("bp_saw_full", 256'(saw_full), 1);
        chk("bp_sent", 256'(sent), 5);
        chk("bp_left", 256'(qsize(3)), 0);
        chk("bp_occ", 256'(b_occ), 0);
        chk("bp_busy", 256'(b_busy), 0);

        // Reset with two transfers in flight; an input during the reset cycle must be ignored
        e_iv = 1; e_ie = MODE_ENC; e_id = 128'(rnd()); e_it = 4'h7;
        tick();
        e_id = 128'(rnd()); e_it = 4'h8;
        tick();
        e_id = 128'(rnd()); e_it = 4'h9; re = 1;
        tick();
        re = 0; e_iv = 0;
        chk("mrst_vld", 256'(e_ov), 0);
        chk("mrst_occ", 256'(e_occ), 0);
        chk("mrst_dat", 256'(e_od), 0);
        chk("mrst_rdy", 256'(e_ir), 1);
        chk("mrst_busy", 256'(e_busy), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mrst_quiet_e", 256'(e_ov), 0);
            chk("mrst_quiet_d", 256'(d_ov), 0);
        end

        // Round trip through the encrypt -> decrypt chain
        lat_on[1] = 1; lat_on[2] = 1;
        e_iv = 1; e_ie = MODE_ENC; e_id = 128'h3243f6a8885a308d313198a2e0370734; e_it = 4'h5;
        tick();
        e_id = 128'h63cab7040953d051cd60e0e7ba70e18c; e_it = 4'hA;
        tick();
        e_iv = 0;
        n_got = 0;
        for (int i = 0; i < 12; i++) begin
            if (d_ov && n_got < 4) begin
                got_d[n_got] = d_od; got_t[n_got] = d_ot; n_got++;
            end
            tick();
        end
        chk("rt_count", 256'(n_got), 2);
        chk("rt_dat0", 256'(got_d[0]), 256'(128'h3243f6a8885a308d313198a2e0370734));
        chk("rt_tag0", 256'(got_t[0]), 256'(4'h5));
        chk("rt_dat1", 256'(got_d[1]), 256'(128'h63cab7040953d051cd60e0e7ba70e18c));
        chk("rt_tag1", 256'(got_t[1]), 256'(4'hA));

        // Random traffic on A and B with random stalls and occasional resets on B
        lat_on[0] = 0;
        for (int i = 0; i < 400; i++) begin
            a_iv = ($urandom_range(0, 3) != 0); a_or = ($urandom_range(0, 2) != 0);
            a_ie = 1'($urandom_range(0, 1));    a_id = 128'(rnd()); a_it = 4'($urandom);
            b_iv = ($urandom_range(0, 3) != 0); b_or = ($urandom_range(0, 2) != 0);
            b_ie = 1'($urandom_range(0, 1));    b_id = rnd();       b_it = 4'($urandom);
            rb   = ($urandom_range(0, 79) == 0);
            tick();
        end
        a_iv = 0; b_iv = 0; a_or = 1; b_or = 1; rb = 0;
        repeat (5) tick();
        chk("rand_left_a", 256'(qsize(0)), 0);
        chk("rand_left_b", 256'(qsize(3)), 0);
        chk("rand_busy_a", 256'(a_busy), 0);
        chk("rand_busy_b", 256'(b_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
